// File: rtl/somador_pkg.sv
// Shared definitions for the BCD adder/display block: FSM encoding,
// digit width and the active-low 7-segment patterns (a..g, MSB first).
package somador_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/somador_bcd_display_seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking.
// Non-decimal codes (10..15) show blank.
module seg7_decoder
    import somador_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic               blank_i,
    output logic [6:0]         seg_o
);

    // Map one digit to its segment pattern, or blank when requested.
    // NOTE: seg_o gets a default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/somador_bcd_display.sv
// Sequential adder with double-dabble binary-to-BCD conversion (one bit per
// clock) and registered active-low 7-segment outputs for DIGITS digits.
module somador_bcd_display
    import somador_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      n1,
    input  logic [WIDTH-1:0]      n2,
    input  logic                  tr0,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH:0]        sum,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  err,
    output logic [7*DIGITS-1:0]   disp
);

    localparam int SW = WIDTH + 1;
    localparam int BW = DIGIT_W * DIGITS;
    localparam int DW = 7 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    state_t          state_q, state_d;
    logic            go_q, go_d;       // operands captured, CONV starts next edge
    logic [SW-1:0]   bin_q, bin_d;     // binary sum, rotated so it survives the conversion
    logic [BW-1:0]   scr_q, scr_d;     // BCD scratch
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            err_q, err_d;
    logic [DW-1:0]   disp_q, disp_d;

    logic [BW-1:0]   adj;
    logic [BW-1:0]   scr_shift;
    logic [SW-1:0]   bin_rot;
    logic            shift_out;
    logic [DIGITS-1:0] blank;
    logic [DW-1:0]   seg_next;
    logic            accept;

    // Add-3 correction on every scratch digit >= 5, then one left shift.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[DIGIT_W*i +: DIGIT_W] >= 4'd5)
                adj[DIGIT_W*i +: DIGIT_W] = scr_q[DIGIT_W*i +: DIGIT_W] + 4'd3;
        end
    end

    assign shift_out = adj[BW-1];
    assign scr_shift = {adj[BW-2:0], bin_q[SW-1]};
    // Rotating instead of shifting returns the original sum after SW steps.
    assign bin_rot   = {bin_q[SW-2:0], bin_q[SW-1]};

    // Leading-zero blanking mask for the result being loaded; units never blank.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        blank = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            seen     = seen | (scr_shift[DIGIT_W*d +: DIGIT_W] != 4'd0);
            blank[d] = (BLANK_LZ != 0) && (d != 0) && !seen;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decoder u_dec (
            .digit_i (scr_shift[DIGIT_W*g +: DIGIT_W]),
            .blank_i (blank[g]),
            .seg_o   (seg_next[7*g +: 7])
        );
    end

    // A request is taken in IDLE (unless one is already pending) or on the
    // DONE cycle, which hands over to IDLE at the same edge.
    assign accept = start && (((state_q == IDLE) && !go_q) || (state_q == DONE));

    // FSM next state, datapath next values and result load.
    always_comb begin
        state_d = state_q;
        go_d    = go_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        bcd_d   = bcd_q;
        err_d   = err_q;
        disp_d  = disp_q;

        case (state_q)
            IDLE: begin
                if (go_q) begin
                    go_d    = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                scr_d = scr_shift;
                bin_d = bin_rot;
                ovf_d = ovf_q | shift_out;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = bin_rot;
                    bcd_d   = scr_shift;
                    err_d   = ovf_q | shift_out;
                    disp_d  = seg_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            go_d  = 1'b1;
            bin_d = {1'b0, n1} + {1'b0, n2} + {{WIDTH{1'b0}}, tr0};
            scr_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end
    end

    // State and result registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            bin_q   <= '0;
            scr_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            bcd_q   <= '0;
            err_q   <= 1'b0;
            disp_q  <= '1;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            bcd_q   <= bcd_d;
            err_q   <= err_d;
            disp_q  <= disp_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign bcd  = bcd_q;
    assign err  = err_q;
    assign disp = disp_q;

endmodule

// File: tb/tb_somador_bcd_display.sv
// Directed bench for somador_bcd_display: three instances cover the default
// configuration, a narrow overflowing one and leading-zero blanking.
module tb_somador_bcd_display;

    logic clk = 1'b0;
    logic rst;

    logic [7:0]  n1_a, n2_a;
    logic        tr0_a, start_a, busy_a, done_a, err_a;
    logic [8:0]  sum_a;
    logic [11:0] bcd_a;
    logic [20:0] disp_a;

    logic [6:0]  n1_b, n2_b;
    logic        tr0_b, start_b, busy_b, done_b, err_b;
    logic [7:0]  sum_b;
    logic [7:0]  bcd_b;
    logic [13:0] disp_b;

    logic [7:0]  n1_c, n2_c;
    logic        tr0_c, start_c, busy_c, done_c, err_c;
    logic [8:0]  sum_c;
    logic [11:0] bcd_c;
    logic [20:0] disp_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    somador_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) u_a (
        .clk(clk), .rst(rst), .n1(n1_a), .n2(n2_a), .tr0(tr0_a), .start(start_a),
        .busy(busy_a), .done(done_a), .sum(sum_a), .bcd(bcd_a), .err(err_a), .disp(disp_a)
    );

    somador_bcd_display #(.WIDTH(7), .DIGITS(2), .BLANK_LZ(0)) u_b (
        .clk(clk), .rst(rst), .n1(n1_b), .n2(n2_b), .tr0(tr0_b), .start(start_b),
        .busy(busy_b), .done(done_b), .sum(sum_b), .bcd(bcd_b), .err(err_b), .disp(disp_b)
    );

    somador_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) u_c (
        .clk(clk), .rst(rst), .n1(n1_c), .n2(n2_c), .tr0(tr0_c), .start(start_c),
        .busy(busy_c), .done(done_c), .sum(sum_c), .bcd(bcd_c), .err(err_c), .disp(disp_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic dut_done(input int which);
        case (which)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    // Pulse start on one instance and count edges until its done is seen.
    task automatic run_conv(input int which, input int x, input int y, input bit c,
                            output int cycles);
        @(negedge clk);
        case (which)
            0:       begin n1_a = 8'(x); n2_a = 8'(y); tr0_a = c; start_a = 1'b1; end
            1:       begin n1_b = 7'(x); n2_b = 7'(y); tr0_b = c; start_b = 1'b1; end
            default: begin n1_c = 8'(x); n2_c = 8'(y); tr0_c = c; start_c = 1'b1; end
        endcase
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        cycles = 0;
        while (cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (dut_done(which)) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int done_cnt;

        rst = 1'b1;
        n1_a = '0; n2_a = '0; tr0_a = 1'b0; start_a = 1'b0;
        n1_b = '0; n2_b = '0; tr0_b = 1'b0; start_b = 1'b0;
        n1_c = '0; n2_c = '0; tr0_c = 1'b0; start_c = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_sum",  sum_a,  0);
        check("rst_bcd",  bcd_a,  0);
        check("rst_err",  err_a,  0);
        check("rst_disp", disp_a, 21'h1FFFFF);
        rst = 1'b0;

        // 200 + 55 + 1 = 256, with latency
        run_conv(0, 200, 55, 1'b1, cyc);
        check("lat_256",  cyc,    10);
        check("busy_done", busy_a, 1);
        check("sum_256",  sum_a,  9'd256);
        check("bcd_256",  bcd_a,  12'h256);
        check("err_256",  err_a,  0);
        check("disp_256", disp_a, {7'b0010010, 7'b0100100, 7'b0100000});
        @(negedge clk);
        check("done_pulse_len", done_a, 0);
        check("busy_after",     busy_a, 0);
        check("sum_hold",       sum_a,  9'd256);

        // Maximum sum
        run_conv(0, 255, 255, 1'b1, cyc);
        check("lat_511", cyc,   10);
        check("sum_511", sum_a, 9'd511);
        check("bcd_511", bcd_a, 12'h511);
        check("err_511", err_a, 0);

        // Overflow on the 2-digit instance
        run_conv(1, 99, 1, 1'b0, cyc);
        check("lat_ovf",  cyc,    9);
        check("sum_ovf",  sum_b,  8'd100);
        check("bcd_ovf",  bcd_b,  8'h00);
        check("err_ovf",  err_b,  1);
        check("disp_ovf", disp_b, {7'b0000001, 7'b0000001});

        // Leading-zero blanking
        run_conv(2, 0, 7, 1'b0, cyc);
        check("bcd_lz7",  bcd_c,  12'h007);
        check("disp_lz7", disp_c, {7'b1111111, 7'b1111111, 7'b0001111});
        run_conv(2, 0, 0, 1'b0, cyc);
        check("disp_lz0", disp_c, {7'b1111111, 7'b1111111, 7'b0000001});
        run_conv(2, 4, 6, 1'b0, cyc);
        check("disp_lz10", disp_c, {7'b1111111, 7'b1001111, 7'b0000001});
        run_conv(2, 100, 5, 1'b0, cyc);
        check("disp_lz105", disp_c, {7'b1001111, 7'b0000001, 7'b0100100});

        // Start during CONV is ignored
        @(negedge clk);
        n1_a = 8'd10; n2_a = 8'd20; tr0_a = 1'b0; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) done_cnt++;
            if (i == 3) begin
                n1_a = 8'd99; n2_a = 8'd99; tr0_a = 1'b1; start_a = 1'b1;
            end
            if (i == 4) start_a = 1'b0;
        end
        check("busy_ign_cnt", done_cnt, 1);
        check("busy_ign_sum", sum_a,    9'd30);
        check("busy_ign_bcd", bcd_a,    12'h030);

        // Reset mid-conversion at cnt = 4
        @(negedge clk);
        n1_a = 8'd1; n2_a = 8'd2; tr0_a = 1'b0; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mid_busy_before", busy_a, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_busy", busy_a, 0);
        check("mid_disp", disp_a, 21'h1FFFFF);
        check("mid_sum",  sum_a,  0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) done_cnt++;
        end
        check("mid_no_done", done_cnt, 0);

        // Normal conversion after the abort
        run_conv(0, 12, 34, 1'b0, cyc);
        check("post_lat",  cyc,    10);
        check("post_sum",  sum_a,  9'd46);
        check("post_bcd",  bcd_a,  12'h046);
        check("post_disp", disp_a, {7'b0000001, 7'b1001100, 7'b0100000});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/somador_bcd_display.md
# somador_bcd_display

Parametrised sequential binary adder with a decimal 7-segment readout. It adds two WIDTH-bit operands plus a carry-in, then converts the (WIDTH+1)-bit sum to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock. It drives DIGITS active-low 7-segment displays. It sits between the board switches/operand registers and the display pins, and replaces the fixed 4-bit, two-digit combinational adder/display path.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥ 2)
- DIGITS, 3, number of decimal digits displayed (≥ 1)
- BLANK_LZ, 0, 1 = blank leading zero digits (units digit never blanked)

Ports:
- clk  in  1  single clock, all state updates on its rising edge
- rst  in  1  reset, synchronous and active-high
- n1  in  WIDTH  operand 1
- n2  in  WIDTH  operand 2
- tr0  in  1  carry-in
- start  in  1  request; sampled only in IDLE
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when new results are valid
- sum  out  WIDTH+1  registered binary sum
- bcd  out  4*DIGITS  registered BCD result, digit d at [4d+3:4d], d=0 is units
- err  out  1  registered; high when the sum exceeds 10^DIGITS−1
- disp  out  7*DIGITS  segments for digit d at [7d+6:7d]; bit 7d+6 = a … bit 7d = g; active-low

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE with start=1: latch n1+n2+tr0 (full WIDTH+1-bit, no truncation) into the shift register. Clear the BCD scratch and overflow scratch. Set cnt=0 and go to CONV.
- CONV, each cycle:
  - Add 3 to every scratch BCD digit ≥ 5.
  - Shift {scratch, binary} left by one.
  - Any 1 shifted out of the top digit sets the overflow scratch.
  - Increment cnt.
  - When the shift with cnt = WIDTH completes (WIDTH+1 shifts in total), load sum, bcd, err and disp, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- busy is 1 in CONV and DONE.
- start outside IDLE is ignored; no queuing.
- Operand changes after the start cycle have no effect on the running conversion.
- sum, bcd, err and disp hold their values until the next DONE load.
- Segment decode, active-low, a..g MSB first:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111
- BLANK_LZ=1: every digit above the highest nonzero digit shows blank; digit 0 always shows its value.
- When err=1, bcd holds the low DIGITS digits of the true value (modulo 10^DIGITS), and disp shows them.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, err=0
  - sum=0, bcd=0
  - disp=all 1s (all digits blank)
- Reset mid-conversion aborts immediately. No done pulse is produced, and outputs return to reset values.
- rst has priority over start in the same cycle.
- Latency: start sampled at edge k; busy=1 from edge k+1; outputs updated and done=1 from edge k+WIDTH+2 for one cycle; busy=0 from edge k+WIDTH+3.
- Back-to-back: the next start is accepted at edge k+WIDTH+3 at the earliest (start held high gives one conversion per WIDTH+3 cycles).
- No combinational path from any input to any output.

## Structure
- Shared package/header somador_pkg holds:
  - the state encoding
  - the ten digit segment patterns and the blank constant
  - the digit-width constant 4
- Sub-module seg7_decoder: combinational 4-bit → 7-segment with a blank input. It is instantiated DIGITS times, and its outputs are registered in the parent on DONE load.
- Double-dabble engine and cnt stay in the top module.

## Test plan
- WIDTH=8, DIGITS=3: n1=200, n2=55, tr0=1, start pulse. Expect:
  - done exactly 10 cycles after the start edge
  - sum=256, bcd=0x256, err=0
  - disp digits 2/5/6 = 0010010/0100100/0100000
- Maximum sum: n1=255, n2=255, tr0=1. Expect sum=511, bcd=0x511, err=0.
- Overflow: WIDTH=7, DIGITS=2, n1=99, n2=1, tr0=0. Expect sum=100, bcd=0x00, err=1.
- Leading-zero blanking: BLANK_LZ=1, n1=0, n2=7, tr0=0. Expect disp = blank, blank, 0001111. Repeat with n1=n2=0: expect blank, blank, 0000001.
- Busy handling: pulse start again mid-CONV with different operands. Expect it ignored, only one done pulse, and results from the first operands.
- Reset: rst=1 for one cycle at cnt=4. Expect no done, busy=0, disp all 1s next cycle. A following start converts normally.
